switch_move_requester: RTL and testbench

Input-side counterpart to the frog movement and game-reset logic. Converts the four raw player switches into debounced, one-move-per-press requests for the frog controller, delivered over a valid/ready handshake. Also detects the all-four-held reset gesture and issues a single `combo_reset` pulse. Sits between the board switch pins and the frog/top-level reset logic.

---
 rtl/frogger_pkg.sv | 25 ++
 rtl/switch_debouncer.sv | 41 ++++
 rtl/switch_move_requester.sv | 148 ++++++++++++++
 tb/tb_switch_move_requester.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared definitions for the frog game: direction codes used by the frog,
// VGA and input logic, plus the move-requester FSM state type.
package frogger_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_HOLD,
      ST_COMBO
   } move_state_t;

   // Switch index i maps to direction code i, so the lowest set bit picks the move.
   function automatic logic [1:0] lowest_dir(input logic [3:0] mask);
      if (mask[0])      lowest_dir = DIR_UP;
      else if (mask[1]) lowest_dir = DIR_DOWN;
      else if (mask[2]) lowest_dir = DIR_LEFT;
      else              lowest_dir = DIR_RIGHT;
   endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability counter for one raw switch pin.
// The debounced level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer into one stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_move_requester.sv
// Turns four raw player switches into one-move-per-press valid/ready requests and
// detects the all-four-held reset gesture. Define AUTO_REPEAT_EN for hold-to-repeat.
module switch_move_requester
   import frogger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int COMBO_CYCLES    = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       switch1,
   input  logic       switch2,
   input  logic       switch3,
   input  logic       switch4,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic       combo_reset,
   output logic [3:0] sw_stable
);

   localparam int CCW = (COMBO_CYCLES > 1) ? $clog2(COMBO_CYCLES) : 1;
   localparam logic [CCW-1:0] COMBO_LAST = CCW'(COMBO_CYCLES - 1);
   localparam logic [CCW-1:0] COMBO_PRE  = CCW'(COMBO_CYCLES - 2);

   logic [3:0]    raw_sw;
   logic [3:0]    stable_d;
   logic [3:0]    press;
   logic [3:0]    other_press;
   logic          all_held;
   logic          none_held;
   logic          combo_done;
   logic          rep_done;
   logic [CCW-1:0] combo_cnt;
   move_state_t   state;
   move_state_t   state_next;
   logic [1:0]    dir_next;

   assign raw_sw = {switch4, switch3, switch2, switch1};

   for (genvar i = 0; i < 4; i++) begin : g_db
      switch_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .raw   (raw_sw[i]),
         .stable(sw_stable[i])
      );
   end

   assign press      = sw_stable & ~stable_d;
   assign all_held   = &sw_stable;
   assign none_held  = ~|sw_stable;
   assign combo_done = (combo_cnt == COMBO_LAST);
   assign move_valid = (state == ST_PEND);

`ifdef AUTO_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt;

   // Cleared everywhere outside HOLD, so each accepted move restarts the hold timer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt <= '0;
      end else if (state != ST_HOLD) begin
         rep_cnt <= '0;
      end else if (rep_cnt != REP_LAST) begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end

   assign rep_done = (rep_cnt == REP_LAST);
`else
   assign rep_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         move_dir <= DIR_UP;
         stable_d <= '0;
      end else begin
         state    <= state_next;
         move_dir <= dir_next;
         stable_d <= sw_stable;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next  = state;
      dir_next    = move_dir;
      // move_dir doubles as the index of the switch being held.
      other_press = press & ~(4'b0001 << move_dir);
      if (state != ST_COMBO && all_held) begin
         state_next = ST_COMBO;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|press) begin
                  dir_next   = lowest_dir(press);
                  state_next = ST_PEND;
               end
            end
            ST_PEND: begin
               if (move_ready) state_next = ST_HOLD;
            end
            ST_HOLD: begin
               if (!sw_stable[move_dir]) begin
                  state_next = ST_IDLE;
               end else if (|other_press) begin
                  dir_next   = lowest_dir(other_press);
                  state_next = ST_PEND;
               end else if (rep_done) begin
                  state_next = ST_PEND;
               end
            end
            ST_COMBO: begin
               if (!combo_done && !all_held) state_next = ST_IDLE;
               else if (combo_done && none_held) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // The counter parks at its last value, which is what suppresses a second pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         combo_cnt   <= '0;
         combo_reset <= 1'b0;
      end else begin
         combo_reset <= 1'b0;
         if (state != ST_COMBO) begin
            combo_cnt <= '0;
         end else if (all_held && !combo_done) begin
            combo_cnt   <= combo_cnt + 1'b1;
            combo_reset <= (combo_cnt == COMBO_PRE);
         end
      end
   end

endmodule

// File: tb/tb_switch_move_requester.sv
// Directed and randomized bench for switch_move_requester with a cycle-level
// reference model built from the behavioural rules of the requester.
module tb_switch_move_requester;

   localparam int D = 4;
   localparam int R = 8;
   localparam int C = 16;
`ifdef AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_PEND  = 1;
   localparam int M_HOLD  = 2;
   localparam int M_COMBO = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] raw = 4'b0000;
   logic       move_ready = 1'b1;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       combo_reset;
   logic [3:0] sw_stable;

   always #5 clk = ~clk;

   switch_move_requester #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (R),
      .COMBO_CYCLES   (C)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .switch1    (raw[0]),
      .switch2    (raw[1]),
      .switch3    (raw[2]),
      .switch4    (raw[3]),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .combo_reset(combo_reset),
      .sw_stable  (sw_stable)
   );

   int vectors = 0;
   int fails   = 0;
   int cyc     = 0;

   // Reference model: pipeline of samples, per-switch run lengths, and a mode.
   bit [3:0] m_s1, m_s2, m_stab, m_prev;
   int       m_run [4];
   int       m_mode, m_dir, m_rep, m_cmb;
   bit       m_pulse;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode = M_IDLE; m_dir = 0; m_rep = 0; m_cmb = 0; m_pulse = 1'b0;
   endtask

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_tick();
      bit [3:0] press;
      bit [3:0] others;
      bit       pulse;
      press  = m_stab & ~m_prev;
      others = press;
      others[m_dir] = 1'b0;
      pulse  = 1'b0;
      if (m_mode == M_COMBO) begin
         if (m_cmb < C - 1) begin
            if (m_stab == 4'hF) begin
               m_cmb = m_cmb + 1;
               pulse = (m_cmb == C - 1);
            end else begin
               m_mode = M_IDLE;
            end
         end else if (m_stab == 4'h0) begin
            m_mode = M_IDLE;
         end
      end else if (m_stab == 4'hF) begin
         m_mode = M_COMBO;
         m_cmb  = 0;
      end else if (m_mode == M_IDLE) begin
         if (press != 0) begin
            m_dir  = lowest(press);
            m_mode = M_PEND;
         end
      end else if (m_mode == M_PEND) begin
         if (move_ready) begin
            m_mode = M_HOLD;
            m_rep  = 0;
         end
      end else begin
         if (!m_stab[m_dir]) m_mode = M_IDLE;
         else if (others != 0) begin
            m_dir  = lowest(others);
            m_mode = M_PEND;
         end else if (AR && m_rep == R - 1) m_mode = M_PEND;
         else if (m_rep < R - 1) m_rep = m_rep + 1;
      end
      m_pulse = pulse;
      m_prev  = m_stab;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] == m_stab[i]) m_run[i] = 0;
         else if (m_run[i] == D - 1) begin
            m_stab[i] = m_s2[i];
            m_run[i]  = 0;
         end else m_run[i] = m_run[i] + 1;
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   function automatic logic [7:0] model_vec();
      return {(m_mode == M_PEND), 2'(m_dir), m_pulse, m_stab};
   endfunction

   function automatic logic [7:0] dut_vec();
      return {move_valid, move_dir, combo_reset, sw_stable};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_tick();
      @(negedge clk);
      cyc++;
      check("cycle", 32'(dut_vec()), 32'(model_vec()));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!move_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, cnt, seen_v, seen_s, pulses;

      // Reset state
      model_reset();
      #1 reset = 1'b0;
      #1 check("reset_state", 32'(dut_vec()), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      steps(4);

      // Glitch shorter than the debounce window
      seen_v = 0; seen_s = 0;
      raw[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         seen_v |= int'(move_valid); seen_s |= int'(|sw_stable);
      end
      raw[2] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen_v |= int'(move_valid); seen_s |= int'(|sw_stable);
      end
      check("glitch_stable", 32'(seen_s), 32'h0);
      check("glitch_valid", 32'(seen_v), 32'h0);

      // Clean press with latency, then hold (repeats only when enabled)
      raw[0] = 1'b1;
      wait_valid(n);
      check("press_latency", 32'(n), 32'(D + 3));
      check("press_dir", 32'(move_dir), 32'd0);
      cnt = 0;
      for (int i = 0; i < 3 * (R + 1); i++) begin
         step();
         cnt += int'(move_valid);
      end
      check("repeat_count", 32'(cnt), AR ? 32'd3 : 32'd0);
      raw = 4'b0000;
      steps(12);

      // Backpressure: switch4 waits, switch2 arrives after the transfer
      move_ready = 1'b0;
      raw[3] = 1'b1;
      wait_valid(n);
      steps(2);
      raw[1] = 1'b1;
      steps(4);
      check("bp_held_valid", 32'(move_valid), 32'd1);
      check("bp_held_dir", 32'(move_dir), 32'd3);
      move_ready = 1'b1;
      n = 0; cnt = 0;
      for (int i = 1; i <= 12 && n == 0; i++) begin
         step();
         if (move_valid && move_dir == 2'd3) cnt++;
         if (move_valid && move_dir == 2'd1) n = i;
      end
      check("bp_next_dir_delay", 32'(n), 32'd3);
      check("bp_single_transfer", 32'(cnt), 32'd0);
      raw = 4'b0000;
      steps(12);

      // Simultaneous press of switch2 and switch3
      raw = 4'b0110;
      wait_valid(n);
      check("simul_dir", 32'(move_dir), 32'd1);
      cnt = 0;
      for (int i = 0; i < R; i++) begin
         step();
         cnt += int'(move_valid);
      end
      check("simul_single", 32'(cnt), 32'd0);
      raw = 4'b0000;
      steps(12);

      // Combo gesture drops the pending move and pulses once
      move_ready = 1'b0;
      raw = 4'b0001;
      wait_valid(n);
      raw = 4'b1111;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         pulses += int'(combo_reset);
      end
      check("combo_pulses", 32'(pulses), 32'd1);
      check("combo_valid_dropped", 32'(move_valid), 32'd0);
      raw = 4'b0000;
      move_ready = 1'b1;
      seen_v = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         seen_v |= int'(move_valid);
      end
      check("combo_no_move_after", 32'(seen_v), 32'd0);
      check("combo_released_stable", 32'(sw_stable), 32'd0);

      // Asynchronous reset while a move is pending
      move_ready = 1'b0;
      raw = 4'b1000;
      wait_valid(n);
      #2 reset = 1'b0;
      #1 check("async_reset", 32'(dut_vec()), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      wait_valid(n);
      check("post_reset_latency", 32'(n), 32'(D + 3));
      check("post_reset_dir", 32'(move_dir), 32'd3);
      move_ready = 1'b1;
      raw = 4'b0000;
      steps(12);

      // Randomized switch activity and backpressure against the model
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(9) == 0) raw[b] = ~raw[b];
         if (i % 150 == 100) raw = 4'b1111;
         move_ready = ($urandom_range(3) != 0);
         step();
      end
      raw = 4'b0000;
      move_ready = 1'b1;
      steps(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
